seq_step_sched: RTL and testbench
=================================

// Module: seq_step_sched
// PURPOSE
//  Round-robin scheduler sharing one 3-bit sequence generator among N_REQ requesters.
//  Each requester asks for req_len steps of the generator's sequence.
//  The scheduler grants one requester at a time and advances the generator once per beat.
//  It forwards each generator value to the winner with valid/last/id tagging.
//  Sits between the shared d_ff-based sequence generator (driven via gen_step) and its clients.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  W       3   generator value width
//  LEN_W   4   width of each per-requester step-count field
// PORTS
//  clk        in   1            rising-edge clock
//  rstb       in   1            asynchronous, active-low reset
//  req        in   N_REQ        per-requester request; held high until its done pulse
//  req_len    in   N_REQ*LEN_W  step count; requester i at bits [i*LEN_W +: LEN_W]
//  gnt        out  N_REQ        one-hot grant, registered
//  done       out  N_REQ        one-cycle completion pulse per requester
//  gen_step   out  1            advance shared generator at this clock edge
//  gen_value  in   W            current generator output
//  out_valid  out  1            beat valid
//  out_data   out  W            generator value for this beat
//  out_last   out  1            final beat of the current grant
//  out_id     out  $clog2(N_REQ) index of granted requester
// BEHAVIOUR
//  Reset (async, rstb=0)
//   - state=IDLE, rr_ptr=0, remain=0; gnt, done, gen_step, out_valid, out_last all 0.
//   - out_data=0 and out_id=0.
//   - Generator is not stepped during reset.
//  States: IDLE, RUN, ZERO.
//  IDLE
//   - Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
//   - On the edge: latch id and remain=req_len[id]; gnt<=onehot(id).
//   - Go to RUN if req_len[id]!=0, otherwise ZERO.
//   - No req: stay in IDLE, all outputs 0.
//  RUN (one beat per cycle, no stalls)
//   - out_valid=1, out_data=gen_value (combinational), out_id=id, gen_step=1.
//   - remain decrements each beat.
//   - out_last=1 and done[id]=1 when remain==1.
//   - After the last beat: gnt<=0, rr_ptr<=id+1 (mod N_REQ), next state IDLE.
//   - req[id] dropped during RUN = abort: that cycle has no beat and no gen_step;
//     no done pulse; gnt<=0; rr_ptr<=id+1; next state IDLE.
//  ZERO
//   - One cycle with gnt[id]=1 and done[id]=1.
//   - out_valid=0, no gen_step; rr_ptr<=id+1; next state IDLE.
//  Timing and widths
//   - Latency: req seen in IDLE at edge k -> gnt and first beat in cycle k+1.
//   - Always one idle cycle between grants.
//   - A grant of L steps occupies exactly L cycles.
//   - Generator value sequence is continuous across grants (never reloaded).
//   - req_len is sampled only at grant; later changes are ignored.
//   - Max L = 2^LEN_W-1.
//  Reset mid-RUN: all outputs clear immediately; no done pulse is issued.
// TESTING
//  Generator model: 3'b101 at reset, sequence 101,110,000,001,010,100,110,000,...
//  1 Single req: req[0]=1, len 3
//    -> gnt=0001 for 3 cycles; data 101,110,000; last+done[0] on 3rd beat;
//       gen_step high for 3 cycles.
//  2 Round-robin: req=1111, all len 1
//    -> grants in order 0,1,2,3,0; one IDLE cycle between each; rr_ptr wraps 3->0.
//  3 Zero length: req[2]=1, len 0
//    -> one cycle gnt=0100 and done[2]; no out_valid; gen_value unchanged.
//  4 Abort: req[1], len 5; drop req[1] after 2 beats
//    -> only 2 beats; no done; next grant goes to requester 2 (or the next one requesting).
//  5 Fairness: req[0] held with len 2 while req[3] asserted mid-grant
//    -> requester 3 is served before requester 0 is granted again.
//  6 Async reset during RUN
//    -> outputs 0 within the same cycle; after release, the first grant searches from index 0.

Source files
------------

// File: rtl/seq_step_sched.sv
// Round-robin scheduler that shares one sequence generator among N_REQ requesters.
// Each grant forwards req_len generator values to the winner, one beat per cycle,
// tagged with valid/last/id. The generator is advanced through gen_step.
module seq_step_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 3,
    parameter int unsigned LEN_W = 4,
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   gen_step,
    input  logic [W-1:0]           gen_value,
    output logic                   out_valid,
    output logic [W-1:0]           out_data,
    output logic                   out_last,
    output logic [ID_W-1:0]        out_id
);

    typedef enum logic [1:0] {StIdle, StRun, StZero} state_e;

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [LEN_W-1:0]   remain_q;
    logic [N_REQ-1:0]   gnt_q;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [LEN_W-1:0]   win_len;
    logic [ID_W-1:0]    id_nxt;
    logic               beat;
    logic               final_beat;

    // Pick the first requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            logic [ID_W-1:0] idx;
            idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
        win_len = req_len[win_id*LEN_W +: LEN_W];
    end

    // A beat happens only while the granted requester still holds its request;
    // a dropped request turns the cycle into an abort with no generator step.
    always_comb begin
        beat       = (state_q == StRun) && req[id_q];
        final_beat = beat && (remain_q == LEN_W'(1));
        id_nxt     = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
    end

    // Grant FSM: idle search, beat-per-cycle run, single-cycle zero-length grant.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            remain_q <= '0;
            gnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        id_q     <= win_id;
                        remain_q <= win_len;
                        gnt_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
                        state_q  <= (win_len != '0) ? StRun : StZero;
                    end
                end
                StRun: begin
                    if (!req[id_q] || final_beat) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= id_nxt;
                        remain_q <= '0;
                        state_q  <= StIdle;
                    end else begin
                        remain_q <= remain_q - 1'b1;
                    end
                end
                StZero: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= id_nxt;
                    state_q  <= StIdle;
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Beat outputs follow the live request so an abort suppresses the beat at once.
    always_comb begin
        gnt       = gnt_q;
        gen_step  = beat;
        out_valid = beat;
        out_data  = beat ? gen_value : '0;
        out_last  = final_beat;
        out_id    = (state_q == StIdle) ? '0 : id_q;
        done      = '0;
        if (final_beat || (state_q == StZero)) begin
            done[id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_step_sched.sv
// Self-checking bench for seq_step_sched: directed vector table, hand-written
// corner sequences, and a randomized run against a grant-level reference model.
module tb_seq_step_sched;

    logic        clk = 1'b0;
    logic        rstb;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        gen_step;
    logic [2:0]  gen_value;
    logic        out_valid;
    logic [2:0]  out_data;
    logic        out_last;
    logic [1:0]  out_id;

    seq_step_sched #(.N_REQ(4), .W(3), .LEN_W(4)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .done      (done),
        .gen_step  (gen_step),
        .gen_value (gen_value),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] gen_next(input logic [2:0] v);
        case (v)
            3'b101:  return 3'b110;
            3'b110:  return 3'b000;
            3'b000:  return 3'b001;
            3'b001:  return 3'b010;
            3'b010:  return 3'b100;
            3'b100:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // Shared generator the scheduler drives.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) gen_value <= 3'b101;
        else if (gen_step) gen_value <= gen_next(gen_value);
    end

    // Output bundle: {gnt[15:12], done[11:8], step[7], valid[6], data[5:3], last[2], id[1:0]}
    wire [15:0] obs = {gnt, done, gen_step, out_valid, out_data, out_last, out_id};

    function automatic logic [15:0] mk(input logic [3:0] g, input logic [3:0] d, input logic s,
                                       input logic v, input logic [2:0] dat, input logic l,
                                       input logic [1:0] id);
        return {g, d, s, v, dat, l, id};
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] last_obs;
    logic [15:0] last_exp;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant is either absent, or in progress with some steps left.
    bit         m_busy;
    int         m_id;
    int         m_left;
    int         m_ptr;
    logic [2:0] m_gen;

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_left = 0; m_ptr = 0; m_gen = 3'b101;
    endtask

    function automatic logic [15:0] model_expect();
        logic [3:0] g, d;
        logic       s, v, l;
        logic [2:0] dat;
        logic [1:0] id;
        g = '0; d = '0; s = 0; v = 0; l = 0; dat = '0; id = '0;
        if (m_busy) begin
            g[m_id] = 1'b1;
            id = 2'(m_id);
            if (m_left == 0) begin
                d[m_id] = 1'b1;
            end else if (req[m_id]) begin
                s = 1; v = 1; dat = m_gen;
                if (m_left == 1) begin
                    l = 1;
                    d[m_id] = 1'b1;
                end
            end
        end
        return {g, d, s, v, dat, l, id};
    endfunction

    task automatic model_step();
        bit found;
        if (m_busy) begin
            if (m_left != 0 && req[m_id]) begin
                m_gen  = gen_next(m_gen);
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_ptr  = (m_id + 1) % 4;
                end
            end else begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % 4;
            end
        end else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!found && req[i]) begin
                    found  = 1;
                    m_busy = 1;
                    m_id   = i;
                    m_left = int'(req_len[i*4 +: 4]);
                end
            end
        end
    endtask

    // One clock cycle: starts just after a rising edge, ends just after the next one.
    task automatic tick(input logic [3:0] r, input logic [15:0] l, input string name);
        req = r;
        req_len = l;
        @(negedge clk);
        last_obs = obs;
        last_exp = model_expect();
        chk(name, last_obs, last_exp);
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[19];

    initial begin
        logic [3:0] r;
        logic [15:0] l;

        // Single grant, zero-length grant, then round-robin with all lengths 1.
        vecs[0]  = '{4'b0001, 16'h0003, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[1]  = '{4'b0001, 16'h0003, mk(4'h1, 4'h0, 1, 1, 3'b101, 0, 2'd0)};
        vecs[2]  = '{4'b0001, 16'h0003, mk(4'h1, 4'h0, 1, 1, 3'b110, 0, 2'd0)};
        vecs[3]  = '{4'b0001, 16'h0003, mk(4'h1, 4'h1, 1, 1, 3'b000, 1, 2'd0)};
        vecs[4]  = '{4'b0000, 16'h0000, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[5]  = '{4'b0100, 16'h0000, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[6]  = '{4'b0100, 16'h0000, mk(4'h4, 4'h4, 0, 0, 3'd0, 0, 2'd2)};
        vecs[7]  = '{4'b0000, 16'h0000, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[8]  = '{4'b1111, 16'h1111, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[9]  = '{4'b1111, 16'h1111, mk(4'h8, 4'h8, 1, 1, 3'b001, 1, 2'd3)};
        vecs[10] = '{4'b1111, 16'h1111, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[11] = '{4'b1111, 16'h1111, mk(4'h1, 4'h1, 1, 1, 3'b010, 1, 2'd0)};
        vecs[12] = '{4'b1111, 16'h1111, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[13] = '{4'b1111, 16'h1111, mk(4'h2, 4'h2, 1, 1, 3'b100, 1, 2'd1)};
        vecs[14] = '{4'b1111, 16'h1111, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[15] = '{4'b1111, 16'h1111, mk(4'h4, 4'h4, 1, 1, 3'b110, 1, 2'd2)};
        vecs[16] = '{4'b1111, 16'h1111, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};
        vecs[17] = '{4'b1111, 16'h1111, mk(4'h8, 4'h8, 1, 1, 3'b000, 1, 2'd3)};
        vecs[18] = '{4'b0000, 16'h0000, mk(4'h0, 4'h0, 0, 0, 3'd0, 0, 2'd0)};

        rstb = 1'b0;
        req = '0;
        req_len = '0;
        model_reset();
        @(posedge clk);
        #1 chk("reset_state", obs, 16'h0000);
        @(posedge clk);
        #1 rstb = 1'b1;

        for (int i = 0; i < 19; i++) begin
            req = vecs[i].req;
            req_len = vecs[i].len;
            @(negedge clk);
            chk($sformatf("table_%0d", i), obs, vecs[i].exp);
            chk($sformatf("table_model_%0d", i), obs, model_expect());
            @(posedge clk);
            model_step();
            #1;
        end

        // Abort: requester 1 asks for 5 steps, drops after 2 beats; requester 2 goes next.
        tick(4'b0010, 16'h0050, "abort_idle");
        tick(4'b0010, 16'h0050, "abort_beat1");
        tick(4'b0010, 16'h0050, "abort_beat2");
        tick(4'b0100, 16'h0200, "abort_cycle");
        chk("abort_no_beat", last_obs, mk(4'h2, 4'h0, 0, 0, 3'd0, 0, 2'd1));
        tick(4'b0100, 16'h0200, "abort_gap");
        tick(4'b0100, 16'h0200, "after_abort_beat1");
        chk("after_abort_gnt", {12'h0, last_obs[15:12]}, 16'h0004);
        tick(4'b0100, 16'h0200, "after_abort_beat2");
        tick(4'b0000, 16'h0000, "after_abort_idle");

        // Fairness: requester 3 arrives mid-grant of 0 and is served before 0 again.
        tick(4'b0001, 16'h1002, "fair_idle");
        tick(4'b0001, 16'h1002, "fair_beat1");
        tick(4'b1001, 16'h1002, "fair_beat2");
        tick(4'b1001, 16'h1002, "fair_gap1");
        tick(4'b1001, 16'h1002, "fair_grant3");
        chk("fair_gnt3", {12'h0, last_obs[15:12]}, 16'h0008);
        tick(4'b0001, 16'h1002, "fair_gap2");
        tick(4'b0001, 16'h1002, "fair_regrant0_b1");
        chk("fair_gnt0", {12'h0, last_obs[15:12]}, 16'h0001);
        tick(4'b0001, 16'h1002, "fair_regrant0_b2");
        tick(4'b0000, 16'h0000, "fair_end");

        // Async reset in the middle of a run, then the search restarts at index 0.
        tick(4'b0100, 16'h0700, "rst_idle");
        tick(4'b0100, 16'h0700, "rst_beat1");
        #1 rstb = 1'b0;
        #1 chk("reset_mid_run", obs, 16'h0000);
        model_reset();
        @(posedge clk);
        #1 rstb = 1'b1;
        tick(4'b1001, 16'h0001, "post_rst_idle");
        tick(4'b1001, 16'h0001, "post_rst_grant");
        chk("post_rst_gnt0", last_obs, mk(4'h1, 4'h1, 1, 1, 3'b101, 1, 2'd0));
        tick(4'b0000, 16'h0000, "post_rst_end");

        // Randomized traffic: requests held until done, occasional aborts,
        // lengths re-randomized every cycle (only the value at grant matters).
        r = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (r[i] && last_exp[8 + i]) r[i] = 1'b0;
                else if (!r[i] && ($urandom % 4 == 0)) r[i] = 1'b1;
                else if (r[i] && ($urandom % 40 == 0)) r[i] = 1'b0;
                l[i*4 +: 4] = ($urandom % 8 == 0) ? 4'd15 : 4'($urandom_range(0, 4));
            end
            tick(r, l, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
